// File: rtl/flash_cmd_seq.sv
// Purpose : StrataFlash command sequencer; expands read / program / erase / status
//           requests into command-byte bus cycles and polls status until ready.
// Latency : first fb_start 1 cycle after accept, next fb_start 1 cycle after each
//           fb_done, cmd_done 1 cycle after the final fb_done.
// Backpressure: one request at a time; cmd_start is ignored unless idle, and each
//           bus cycle stalls until fb_done returns.
// Ports   : CLK_50MHZ/RST (async active-low) ; cmd_* controller request/response ;
//           fb_* / direction_rw bus-cycle handshake to the Flash bus-cycle block.
module flash_cmd_seq #(
  parameter int MAX_POLLS = 1000,
  parameter int POLL_W    = 10
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       cmd_start,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       cmd_busy,
  output logic       cmd_done,
  output logic [7:0] cmd_rdata,
  output logic       cmd_error,
  output logic [7:0] fb_addr,
  output logic [7:0] fb_wdata,
  input  logic [7:0] fb_rdata,
  output logic       direction_rw,
  output logic       fb_start,
  input  logic       fb_done
);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_PROG   = 2'b01;
  localparam logic [1:0] OP_STATUS = 2'b11;

  typedef enum logic [3:0] {
    IDLE, CMD1, CMD2, STS_CMD, POLL, CLR_STS, READ_ARRAY, RD_DATA, FINISH
  } state_t;

  state_t            state;
  logic              wait_ph;   // 0 = ISSUE (fb_start high), 1 = WAIT for fb_done
  logic [1:0]        op_q;
  logic [7:0]        wdata_q;
  logic [POLL_W-1:0] poll_cnt;
  logic              err_q;     // error seen so far; published only at cmd_done

  state_t nxt_state;
  logic   nxt_done;
  logic   nxt_err;

  // Command byte driven for the write cycle of a given state.
  function automatic logic [7:0] cmd_byte(input state_t s, input logic [1:0] op,
                                          input logic [7:0] wd);
    case (s)
      CMD1:       return (op == OP_PROG) ? 8'h40 : 8'h20;
      CMD2:       return (op == OP_PROG) ? wd : 8'hD0;
      STS_CMD:    return 8'h70;
      CLR_STS:    return 8'h50;
      READ_ARRAY: return 8'hFF;
      default:    return 8'h00;
    endcase
  endfunction

  function automatic state_t first_state(input logic [1:0] op);
    case (op)
      OP_READ:   return READ_ARRAY;
      OP_STATUS: return STS_CMD;
      default:   return CMD1;
    endcase
  endfunction

  // Where the sequence goes when the current bus cycle completes.
  always_comb begin
    nxt_state = IDLE;
    nxt_done  = 1'b0;
    nxt_err   = 1'b0;
    case (state)
      CMD1:    nxt_state = CMD2;
      CMD2:    nxt_state = STS_CMD;
      STS_CMD: nxt_state = (op_q == OP_STATUS) ? RD_DATA : POLL;
      POLL: begin
        if (fb_rdata[7]) begin
          if (|fb_rdata[5:3]) begin
            nxt_state = CLR_STS;
            nxt_err   = 1'b1;
          end else begin
            nxt_state = READ_ARRAY;
          end
        end else if (poll_cnt == POLL_W'(MAX_POLLS - 1)) begin
          // Last allowed read still busy: give up, clear status, return to array mode.
          nxt_state = CLR_STS;
          nxt_err   = 1'b1;
        end else begin
          nxt_state = POLL;
        end
      end
      CLR_STS: nxt_state = READ_ARRAY;
      READ_ARRAY: begin
        if (op_q == OP_READ) nxt_state = RD_DATA;
        else                 nxt_done  = 1'b1;
      end
      RD_DATA: nxt_done = 1'b1;
      default: nxt_done = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      wait_ph      <= 1'b0;
      op_q         <= 2'b00;
      wdata_q      <= 8'h00;
      poll_cnt     <= '0;
      err_q        <= 1'b0;
      cmd_busy     <= 1'b0;
      cmd_done     <= 1'b0;
      cmd_rdata    <= 8'h00;
      cmd_error    <= 1'b0;
      fb_addr      <= 8'h00;
      fb_wdata     <= 8'h00;
      direction_rw <= 1'b0;
      fb_start     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_done <= 1'b0;
          if (cmd_start) begin
            op_q         <= cmd_op;
            wdata_q      <= cmd_wdata;
            fb_addr      <= cmd_addr;
            cmd_busy     <= 1'b1;
            cmd_error    <= 1'b0;
            err_q        <= 1'b0;
            poll_cnt     <= '0;
            state        <= first_state(cmd_op);
            wait_ph      <= 1'b0;
            // Every sequence opens with a write cycle.
            fb_start     <= 1'b1;
            direction_rw <= 1'b1;
            fb_wdata     <= cmd_byte(first_state(cmd_op), cmd_op, cmd_wdata);
          end
        end
        FINISH: begin
          cmd_done <= 1'b0;
          state    <= IDLE;
        end
        CMD1, CMD2, STS_CMD, POLL, CLR_STS, READ_ARRAY, RD_DATA: begin
          if (!wait_ph) begin
            fb_start <= 1'b0;
            wait_ph  <= 1'b1;
          end else if (fb_done) begin
            if (state == POLL || state == RD_DATA) cmd_rdata <= fb_rdata;
            if (state == POLL) poll_cnt <= poll_cnt + 1'b1;
            if (nxt_done) begin
              state     <= FINISH;
              cmd_done  <= 1'b1;
              cmd_busy  <= 1'b0;
              cmd_error <= err_q;
            end else begin
              state        <= nxt_state;
              wait_ph      <= 1'b0;
              fb_start     <= 1'b1;
              direction_rw <= !(nxt_state == POLL || nxt_state == RD_DATA);
              fb_wdata     <= cmd_byte(nxt_state, op_q, wdata_q);
              if (nxt_err) err_q <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          wait_ph  <= 1'b0;
          fb_start <= 1'b0;
          cmd_busy <= 1'b0;
          cmd_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_seq.sv
module tb_flash_cmd_seq;
  localparam int MP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_start = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_busy, cmd_done, cmd_error;
  logic [7:0] cmd_rdata;
  logic [7:0] fb_addr, fb_wdata;
  logic [7:0] fb_rdata = 8'h00;
  logic       direction_rw, fb_start;
  logic       fb_done = 1'b0;

  always #10 clk = ~clk;

  flash_cmd_seq #(.MAX_POLLS(MP), .POLL_W(3)) dut (
    .CLK_50MHZ(clk), .RST(rst_n),
    .cmd_start(cmd_start), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_rdata(cmd_rdata), .cmd_error(cmd_error),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata),
    .direction_rw(direction_rw), .fb_start(fb_start), .fb_done(fb_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter, completion counter, fb_start-during-reset watcher.
  int cyc = 0;
  int done_cnt = 0;
  int rst_start_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cmd_done) done_cnt <= done_cnt + 1;
    if (!rst_n && fb_start) rst_start_bad <= rst_start_bad + 1;
  end

  // Flash bus-cycle model: logs each bus cycle, answers after a delay.
  logic [16:0] logv [0:4095];
  int          log_n = 0;
  int          hold_bad = 0;
  logic [7:0]  resp [0:7];
  int          txn = 0;
  int          fix_dly = 0;
  int          rst_cnt = 0;
  int          spur_req = 0;

  initial begin : flash_model
    int idx, my_txn, my_rst, d, spur_ack;
    logic [16:0] e;
    logic [7:0]  wd_seen;
    idx = 0; my_txn = 0; spur_ack = 0;
    forever begin
      @(negedge clk);
      fb_done = 1'b0;
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        fb_rdata = 8'h5A;
        fb_done  = 1'b1;
      end else if (fb_start) begin
        if (txn != my_txn) begin
          my_txn = txn;
          idx = 0;
        end
        e = {direction_rw, fb_addr, direction_rw ? fb_wdata : 8'h00};
        wd_seen = fb_wdata;
        if (log_n < 4096) logv[log_n] = e;
        log_n++;
        my_rst = rst_cnt;
        d = (fix_dly > 0) ? fix_dly : int'($urandom_range(1, 4));
        repeat (d) @(negedge clk);
        if (my_rst == rst_cnt &&
            {direction_rw, fb_addr, fb_wdata} !== {e[16:8], wd_seen}) hold_bad++;
        if (e[16]) fb_rdata = 8'h00;
        else begin
          fb_rdata = (idx < 8) ? resp[idx] : 8'h00;
          idx++;
        end
        fb_done = 1'b1;
      end
    end
  end

  // Reference model: expected bus cycles and result, from the command rules.
  logic [16:0] exp_q[$];

  function automatic logic [16:0] bw(input logic [7:0] a, input logic [7:0] b);
    return {1'b1, a, b};
  endfunction
  function automatic logic [16:0] br(input logic [7:0] a);
    return {1'b0, a, 8'h00};
  endfunction

  task automatic build_exp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                           output logic [7:0] rd, output logic er);
    logic ready;
    logic [7:0] s;
    exp_q.delete();
    rd = 8'h00; er = 1'b0;
    if (op == 2'b00 || op == 2'b11) begin
      exp_q.push_back(bw(a, (op == 2'b00) ? 8'hFF : 8'h70));
      exp_q.push_back(br(a));
      rd = resp[0];
    end else begin
      exp_q.push_back(bw(a, (op == 2'b01) ? 8'h40 : 8'h20));
      exp_q.push_back(bw(a, (op == 2'b01) ? wd : 8'hD0));
      exp_q.push_back(bw(a, 8'h70));
      ready = 1'b0;
      for (int i = 0; i < MP; i++) begin
        exp_q.push_back(br(a));
        s = resp[i];
        rd = s;
        if (s[7]) begin
          ready = 1'b1;
          break;
        end
      end
      s = rd;
      er = !ready || (s[5:3] != 3'b000);
      if (er) exp_q.push_back(bw(a, 8'h50));
      exp_q.push_back(bw(a, 8'hFF));
    end
  endtask

  task automatic run_cmd(input string nm, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] wd, input bit junk, output int lat);
    logic [7:0] erd;
    logic er;
    int base, dbase, acc;
    bit got;
    build_exp(op, a, wd, erd, er);
    txn++;
    base = log_n; dbase = done_cnt;
    cmd_start = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd;
    acc = cyc;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
    chk({nm, "_busy"}, 32'(cmd_busy), 1);
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (cmd_done) begin
        got = 1'b1;
        break;
      end
      cmd_start = junk && (k % 3 == 1);
      @(negedge clk);
    end
    lat = cyc - acc;
    chk({nm, "_done"}, 32'(got), 1);
    chk({nm, "_rdata"}, 32'(cmd_rdata), 32'(erd));
    chk({nm, "_error"}, 32'(cmd_error), 32'(er));
    cmd_start = junk;  // strobe in the cmd_done cycle must be ignored too
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (8) @(negedge clk);
    chk({nm, "_ndone"}, 32'(done_cnt - dbase), 1);
    chk({nm, "_ncyc"}, 32'(log_n - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < log_n) chk({nm, "_cyc"}, 32'(logv[base + i]), 32'(exp_q[i]));
    chk({nm, "_idle"}, 32'(cmd_busy), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin : main
    int lat, b, dc, nw;
    logic [1:0] op;
    logic [7:0] s;
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({cmd_busy, cmd_done, cmd_error, direction_rw, fb_start}), 0);
    chk("rst_rdata", 32'(cmd_rdata), 0);
    chk("rst_bus", 32'({fb_addr, fb_wdata}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: read with fixed 3-cycle Flash response.
    fix_dly = 3;
    resp[0] = 8'hC9;
    run_cmd("read", 2'b00, 8'h35, 8'h00, 1'b0, lat);
    chk("read_lat", 32'(lat), 9);
    fix_dly = 0;

    resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h80;
    run_cmd("prog", 2'b01, 8'h35, 8'hC9, 1'b0, lat);

    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    resp[0] = 8'hA0;
    run_cmd("erase_err", 2'b10, 8'hF8, 8'h00, 1'b0, lat);

    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    run_cmd("timeout", 2'b01, 8'h12, 8'h34, 1'b0, lat);

    resp[0] = 8'h88;
    run_cmd("status", 2'b11, 8'h07, 8'h00, 1'b0, lat);

    // Unsolicited fb_done while idle.
    b = log_n; dc = done_cnt;
    spur_req++;
    repeat (6) @(negedge clk);
    chk("spur_cyc", 32'(log_n - b), 0);
    chk("spur_done", 32'(done_cnt - dc), 0);

    // Strobes while busy and in the cmd_done cycle.
    resp[0] = 8'h00; resp[1] = 8'h80;
    run_cmd("junk", 2'b10, 8'h44, 8'h00, 1'b1, lat);

    // Reset in the middle of an erase poll.
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    txn++;
    b = log_n;
    cmd_start = 1'b1; cmd_op = 2'b10; cmd_addr = 8'h66;
    @(negedge clk);
    cmd_start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (log_n - b >= 4) break;
      @(negedge clk);
    end
    chk("rst_reach_poll", 32'(log_n - b >= 4), 1);
    #3;
    rst_cnt++;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out", 32'({cmd_busy, cmd_done, cmd_error, direction_rw, fb_start,
                            cmd_rdata, fb_addr, fb_wdata}), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_no_fbstart", 32'(rst_start_bad), 0);
    chk("rst_idle", 32'({cmd_busy, fb_start}), 0);
    resp[0] = 8'h3C;
    run_cmd("post_rst_read", 2'b00, 8'h9A, 8'h00, 1'b0, lat);

    // Randomized commands against the reference model.
    for (int t = 0; t < 24; t++) begin
      op = 2'($urandom);
      for (int i = 0; i < 8; i++) resp[i] = 8'($urandom_range(0, 127));
      if (op == 2'b01 || op == 2'b10) begin
        nw = $urandom_range(0, MP);
        if (nw < MP) begin
          s = 8'h80 | 8'($urandom_range(0, 127));
          if ($urandom_range(0, 1) == 1) s[5:3] = 3'b000;
          resp[nw] = s;
        end
      end else begin
        resp[0] = 8'($urandom);
      end
      run_cmd("rand", op, 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)), lat);
    end

    chk("bus_hold", 32'(hold_bad), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
